// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_write_arbiter_pkg                                                  |
// | Register-file types shared by the writeback arbiter and its requesters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package regfile_write_arbiter_pkg;

    typedef logic [31:0] t_reg;
    typedef logic [3:0]  t_reg_index;

    typedef enum logic [1:0] {
        IT_BOTTOM   = 2'd0,
        IT_TOP      = 2'd1,
        IT_UNSIGNED = 2'd2,
        IT_SIGNED   = 2'd3
    } t_immediate_type;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_LOAD = 2'd1,
        WB_ALU  = 2'd2,
        WB_IMM  = 2'd3
    } t_wb_source;

    function automatic logic [15:0] index_onehot(input t_reg_index idx);
        index_onehot = 16'h0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_write_arbiter_if                                                   |
// | Writeback request handshakes and register-file write port bundle.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic            load_valid;
    logic            load_ready;
    t_reg_index      load_index;
    t_reg            load_data;

    logic            alu_valid;
    logic            alu_ready;
    t_reg_index      alu_index;
    t_reg            alu_data;

    logic            imm_valid;
    logic            imm_ready;
    t_reg_index      imm_index;
    logic [15:0]     imm_data;
    t_immediate_type imm_type;

    logic            write;
    logic            write_immediate;
    t_reg_index      write_index;
    t_reg            write_data;
    logic [15:0]     write_immediate_data;
    t_immediate_type write_immediate_type;
    t_wb_source      grant_source;
    logic [15:0]     pending_mask;

    // Requesters and the register-file side.
    modport master (
        output load_valid, load_index, load_data,
        output alu_valid, alu_index, alu_data,
        output imm_valid, imm_index, imm_data, imm_type,
        input  load_ready, alu_ready, imm_ready,
        input  write, write_immediate, write_index, write_data,
        input  write_immediate_data, write_immediate_type, grant_source, pending_mask
    );

    // The arbiter.
    modport slave (
        input  load_valid, load_index, load_data,
        input  alu_valid, alu_index, alu_data,
        input  imm_valid, imm_index, imm_data, imm_type,
        output load_ready, alu_ready, imm_ready,
        output write, write_immediate, write_index, write_data,
        output write_immediate_data, write_immediate_type, grant_source, pending_mask
    );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_priority_select                                                         |
// | One-hot writeback winner: promoted IMM > promoted ALU > LOAD > ALU > IMM.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_priority_select
    import regfile_write_arbiter_pkg::*;
(
    input  wire logic       load_valid,
    input  wire logic       alu_valid,
    input  wire logic       imm_valid,
    input  wire logic       alu_promote,
    input  wire logic       imm_promote,
    output      logic [2:0] grant,      // [0]=LOAD [1]=ALU [2]=IMM
    output      t_wb_source source
);

    always_comb begin
        grant  = 3'b000;
        source = WB_NONE;
        if (imm_promote && imm_valid) begin
            grant  = 3'b100;
            source = WB_IMM;
        end else if (alu_promote && alu_valid) begin
            grant  = 3'b010;
            source = WB_ALU;
        end else if (load_valid) begin
            grant  = 3'b001;
            source = WB_LOAD;
        end else if (alu_valid) begin
            grant  = 3'b010;
            source = WB_ALU;
        end else if (imm_valid) begin
            grant  = 3'b100;
            source = WB_IMM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_write_arbiter                                                      |
// | Shares the register-file write port among LOAD, ALU and IMM writebacks.    |
// | Optional anti-starvation promotion: define REGFILE_ARB_STARVE_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input wire logic               clock,
    input wire logic               reset,
    regfile_write_arbiter_if.slave wb
);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_range_check
            $error("STARVE_LIMIT must be within 1..15");
        end
    endgenerate

    logic [2:0]      w_grant;
    t_wb_source      w_source;
    logic            w_alu_promote;
    logic            w_imm_promote;
    logic            w_xfer;

    logic            r_write;
    logic            r_write_imm;
    t_reg_index      r_index;
    t_reg            r_data;
    logic [15:0]     r_imm_data;
    t_immediate_type r_imm_type;
    t_wb_source      r_source;

    wb_priority_select u_select (
        .load_valid  (wb.load_valid),
        .alu_valid   (wb.alu_valid),
        .imm_valid   (wb.imm_valid),
        .alu_promote (w_alu_promote),
        .imm_promote (w_imm_promote),
        .grant       (w_grant),
        .source      (w_source)
    );

    // Readies are held low during reset so nothing is accepted on that edge.
    assign wb.load_ready = w_grant[0] & ~reset;
    assign wb.alu_ready  = w_grant[1] & ~reset;
    assign wb.imm_ready  = w_grant[2] & ~reset;
    assign w_xfer        = (|w_grant) & ~reset;

`ifdef REGFILE_ARB_STARVE_EN
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_alu_wait;
    logic [3:0] r_imm_wait;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_alu_wait <= 4'd0;
            r_imm_wait <= 4'd0;
        end else begin
            if (!wb.alu_valid || wb.alu_ready) begin
                r_alu_wait <= 4'd0;
            end else if (r_alu_wait != c_starve_limit) begin
                r_alu_wait <= r_alu_wait + 4'd1;
            end
            if (!wb.imm_valid || wb.imm_ready) begin
                r_imm_wait <= 4'd0;
            end else if (r_imm_wait != c_starve_limit) begin
                r_imm_wait <= r_imm_wait + 4'd1;
            end
        end
    end

    assign w_alu_promote = (r_alu_wait == c_starve_limit);
    assign w_imm_promote = (r_imm_wait == c_starve_limit);
`else
    assign w_alu_promote = 1'b0;
    assign w_imm_promote = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_write     <= 1'b0;
            r_write_imm <= 1'b0;
            r_index     <= '0;
            r_data      <= '0;
            r_imm_data  <= 16'h0000;
            r_imm_type  <= IT_BOTTOM;
            r_source    <= WB_NONE;
        end else begin
            r_write     <= 1'b0;
            r_write_imm <= 1'b0;
            r_source    <= WB_NONE;
            if (w_xfer) begin
                r_source <= w_source;
                unique case (w_source)
                    WB_LOAD: begin
                        r_write <= 1'b1;
                        r_index <= wb.load_index;
                        r_data  <= wb.load_data;
                    end
                    WB_ALU: begin
                        r_write <= 1'b1;
                        r_index <= wb.alu_index;
                        r_data  <= wb.alu_data;
                    end
                    WB_IMM: begin
                        r_write_imm <= 1'b1;
                        r_index     <= wb.imm_index;
                        r_imm_data  <= wb.imm_data;
                        r_imm_type  <= wb.imm_type;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wb.write                = r_write;
    assign wb.write_immediate      = r_write_imm;
    assign wb.write_index          = r_index;
    assign wb.write_data           = r_data;
    assign wb.write_immediate_data = r_imm_data;
    assign wb.write_immediate_type = r_imm_type;
    assign wb.grant_source         = r_source;

    // Hazard mask: every waiting request plus the write currently on the port.
    assign wb.pending_mask =
          (wb.load_valid ? index_onehot(wb.load_index) : 16'h0000)
        | (wb.alu_valid  ? index_onehot(wb.alu_index)  : 16'h0000)
        | (wb.imm_valid  ? index_onehot(wb.imm_index)  : 16'h0000)
        | ((r_write || r_write_imm) ? index_onehot(r_index) : 16'h0000);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_write_arbiter                                                   |
// | Directed self-checking bench for the writeback arbiter.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   load_writes;

    regfile_write_arbiter_if wb ();

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (wb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        load_writes = 0;
        reset = 1'b1;
        wb.load_valid = 1'b1; wb.load_index = 4'd1; wb.load_data = 32'd1;
        wb.alu_valid  = 1'b1; wb.alu_index  = 4'd4; wb.alu_data  = 32'd4;
        wb.imm_valid  = 1'b1; wb.imm_index  = 4'd5; wb.imm_data  = 16'h1234;
        wb.imm_type   = IT_UNSIGNED;

        // Reset with every requester valid.
        tick(); tick();
        check("rst_load_ready", 32'(wb.load_ready), 32'd0);
        check("rst_alu_ready", 32'(wb.alu_ready), 32'd0);
        check("rst_imm_ready", 32'(wb.imm_ready), 32'd0);
        check("rst_write", 32'(wb.write), 32'd0);
        check("rst_write_imm", 32'(wb.write_immediate), 32'd0);
        check("rst_source", 32'(wb.grant_source), 32'(WB_NONE));
        check("rst_index", 32'(wb.write_index), 32'd0);
        check("rst_data", wb.write_data, 32'd0);
        check("rst_imm_data", 32'(wb.write_immediate_data), 32'd0);
        check("rst_imm_type", 32'(wb.write_immediate_type), 32'(IT_BOTTOM));

        reset = 1'b0;
        #1;
        check("rel_load_ready", 32'(wb.load_ready), 32'd1);
        check("rel_alu_ready", 32'(wb.alu_ready), 32'd0);
        check("rel_imm_ready", 32'(wb.imm_ready), 32'd0);
        wb.load_valid = 1'b0; wb.alu_valid = 1'b0; wb.imm_valid = 1'b0;
        tick();
        check("idle_write", 32'(wb.write), 32'd0);

        // ALU alone: r2 <- deadbeef.
        wb.alu_valid = 1'b1; wb.alu_index = 4'd2; wb.alu_data = 32'hdeadbeef;
        #1;
        check("alu_ready", 32'(wb.alu_ready), 32'd1);
        check("alu_mask_req", 32'(wb.pending_mask), 32'h0004);
        tick();
        wb.alu_valid = 1'b0;
        #1;
        check("alu_write", 32'(wb.write), 32'd1);
        check("alu_write_imm", 32'(wb.write_immediate), 32'd0);
        check("alu_index", 32'(wb.write_index), 32'd2);
        check("alu_data", wb.write_data, 32'hdeadbeef);
        check("alu_source", 32'(wb.grant_source), 32'(WB_ALU));
        check("alu_mask_out", 32'(wb.pending_mask), 32'h0004);

        // IMM alone: r3, ffff, signed.
        wb.imm_valid = 1'b1; wb.imm_index = 4'd3; wb.imm_data = 16'hffff; wb.imm_type = IT_SIGNED;
        tick();
        wb.imm_valid = 1'b0;
        #1;
        check("imm_write_imm", 32'(wb.write_immediate), 32'd1);
        check("imm_write", 32'(wb.write), 32'd0);
        check("imm_index", 32'(wb.write_index), 32'd3);
        check("imm_payload", 32'(wb.write_immediate_data), 32'h0000ffff);
        check("imm_type", 32'(wb.write_immediate_type), 32'(IT_SIGNED));
        check("imm_data_held", wb.write_data, 32'hdeadbeef);
        check("imm_source", 32'(wb.grant_source), 32'(WB_IMM));

        // Idle cycle: strobes drop, index holds.
        tick();
        check("idle_write2", 32'(wb.write), 32'd0);
        check("idle_write_imm2", 32'(wb.write_immediate), 32'd0);
        check("idle_source", 32'(wb.grant_source), 32'(WB_NONE));
        check("idle_index_hold", 32'(wb.write_index), 32'd3);
        check("idle_mask", 32'(wb.pending_mask), 32'h0000);

        // Three simultaneous requesters drain in priority order.
        wb.load_valid = 1'b1; wb.load_index = 4'd1; wb.load_data = 32'd1;
        wb.alu_valid  = 1'b1; wb.alu_index  = 4'd4; wb.alu_data  = 32'd4;
        wb.imm_valid  = 1'b1; wb.imm_index  = 4'd5; wb.imm_data  = 16'h1234; wb.imm_type = IT_UNSIGNED;
        #1;
        check("tri_mask0", 32'(wb.pending_mask), 32'h0032);
        check("tri_load_ready", 32'(wb.load_ready), 32'd1);
        tick();
        wb.load_valid = 1'b0;
        #1;
        check("tri_mask1", 32'(wb.pending_mask), 32'h0032);
        check("tri_w1_index", 32'(wb.write_index), 32'd1);
        check("tri_w1_source", 32'(wb.grant_source), 32'(WB_LOAD));
        check("tri_alu_ready", 32'(wb.alu_ready), 32'd1);
        tick();
        wb.alu_valid = 1'b0;
        #1;
        check("tri_mask2", 32'(wb.pending_mask), 32'h0030);
        check("tri_w2_index", 32'(wb.write_index), 32'd4);
        check("tri_w2_data", wb.write_data, 32'd4);
        tick();
        wb.imm_valid = 1'b0;
        #1;
        check("tri_mask3", 32'(wb.pending_mask), 32'h0020);
        check("tri_w3_index", 32'(wb.write_index), 32'd5);
        check("tri_w3_imm", 32'(wb.write_immediate), 32'd1);
        check("tri_w3_payload", 32'(wb.write_immediate_data), 32'h1234);
        check("tri_w3_type", 32'(wb.write_immediate_type), 32'(IT_UNSIGNED));
        tick();
        check("tri_mask4", 32'(wb.pending_mask), 32'h0000);
        check("tri_done_write", 32'(wb.write), 32'd0);

        // Continuous LOAD stream against a waiting ALU request.
        wb.load_valid = 1'b1; wb.load_index = 4'd7; wb.load_data = 32'h55;
        wb.alu_valid  = 1'b1; wb.alu_index  = 4'd8; wb.alu_data  = 32'h88;
        #1;
`ifdef REGFILE_ARB_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            check("starve_alu_refused", 32'(wb.alu_ready), 32'd0);
            tick();
        end
        check("starve_alu_promoted", 32'(wb.alu_ready), 32'd1);
        check("starve_load_blocked", 32'(wb.load_ready), 32'd0);
        tick();
        wb.alu_valid = 1'b0;
        #1;
        check("starve_alu_source", 32'(wb.grant_source), 32'(WB_ALU));
        check("starve_alu_index", 32'(wb.write_index), 32'd8);
        check("starve_load_resumes", 32'(wb.load_ready), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            check("nostarve_alu_ready", 32'(wb.alu_ready), 32'd0);
            tick();
            if (wb.write && wb.grant_source == WB_LOAD && wb.write_index == 4'd7)
                load_writes++;
        end
        check("nostarve_load_writes", 32'(load_writes), 32'd20);
`endif
        wb.load_valid = 1'b0;
        wb.alu_valid  = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port among three writeback requesters: memory load, ALU result and immediate load. It sits between the execute/memory stages and `register_file`. It accepts at most one request per cycle over valid/ready handshakes. It presents the winner as a registered write, one cycle later, on the register file's `write` / `write_immediate` port. It also exports a pending-write mask so issue logic can stall on hazards.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: cycles a waiting requester may be refused before promotion (used only with `REGFILE_ARB_STARVE_EN`); legal range 1–15.

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_valid` / `load_ready`  in / out  1  load writeback handshake.
- `load_index` / `load_data`  in  t_reg_index / t_reg  load target and word.
- `alu_valid` / `alu_ready`  in / out  1  ALU writeback handshake.
- `alu_index` / `alu_data`  in  t_reg_index / t_reg  ALU target and word.
- `imm_valid` / `imm_ready`  in / out  1  immediate writeback handshake.
- `imm_index`  in  t_reg_index  immediate target.
- `imm_data`  in  16  immediate payload.
- `imm_type`  in  t_immediate_type  immediate type: IT_BOTTOM / IT_TOP / IT_UNSIGNED / IT_SIGNED.
- `write`  out  1  full-word write strobe to register file.
- `write_immediate`  out  1  immediate write strobe to register file.
- `write_index`  out  t_reg_index  register file write target.
- `write_data`  out  t_reg  register file write word.
- `write_immediate_data`  out  16  register file immediate payload.
- `write_immediate_type`  out  t_immediate_type  register file immediate type.
- `grant_source`  out  t_wb_source  source of the current registered write.
- `pending_mask`  out  16  bit n set while any valid, not-yet-accepted request targets rn, or a registered write to rn is on the outputs.

## Operation
- **Transfer rule:** a transfer occurs on a rising edge where `x_valid && x_ready`.
  - Requester rules: `valid` may not drop, and payload may not change, until the transfer.
- **Readies:** combinational from the current valids and counters.
  - Exactly one ready is high when any valid is high; none otherwise.
  - A ready never asserts without its own valid.
- **Default priority:** LOAD > ALU > IMM.
- **Output register:** on a transfer, the winner's payload is loaded into the output register.
  - LOAD/ALU winner: `write`=1, `write_immediate`=0, `write_data` = payload.
  - IMM winner: `write_immediate`=1, `write`=0, immediate fields = payload.
- **Idle cycles:** with no transfer, both strobes are 0, `grant_source`=WB_NONE, and data/index hold their last values.
- **Mutual exclusion:** `write` and `write_immediate` are never high together.
- **Same-index requests:** the arbiter does not order them. Issue logic must not launch a write to a register whose `pending_mask` bit is set.
- **Reset:**
  - All strobes 0, `grant_source`=WB_NONE.
  - `write_index`=0, `write_data`=0, `write_immediate_data`=0, `write_immediate_type`=IT_BOTTOM.
  - Counters 0; all readies 0 while `reset`=1.
- **Reset mid-operation:** a request accepted on the same edge as reset is discarded. Requesters must re-present it after reset.

## Timing
- **Latency:** handshake edge N → strobe high during cycle N+1 → register file commits at edge N+1. Readback through register file read ports is valid after edge N+1.
- **Throughput:** one write per cycle, back-to-back.
- **Full word ready path:** combinational from valids (no registered ready); no internal buffering beyond the output register.
- **`pending_mask` timing:** combinational OR of the valid requests' one-hot indices and the registered output's one-hot index (when a strobe is high).

## Configuration
- **`REGFILE_ARB_STARVE_EN` defined:**
  - Each of ALU and IMM has a wait counter. It increments on cycles with `valid && !ready` and saturates at `STARVE_LIMIT`.
  - The counter clears on that requester's transfer or when its valid is low.
  - A requester whose counter equals `STARVE_LIMIT` is promoted above all non-promoted requesters. Among promoted requesters, IMM ranks above ALU.
  - LOAD is never promoted and never starves.
- **Undefined:** pure fixed priority with no counters; a continuous LOAD stream may starve ALU/IMM indefinitely.

## Structure
- **Shared `registers.vh` package:**
  - Existing: t_reg, t_reg_index, t_immediate_type.
  - Add: t_wb_source (WB_NONE, WB_LOAD, WB_ALU, WB_IMM).
- **Sub-module `wb_priority_select`:** combinational. Takes three valids and two promote flags; returns a one-hot grant and a t_wb_source.
- **Top level:** counters, output register and mask.

## Test plan
- Reset with all valids high → readies 0, `write`=0, `write_immediate`=0, `grant_source`=WB_NONE. After release: `load_ready`=1 only.
- ALU alone: r2 ← 32'hdeadbeef → next cycle `write`=1, `write_index`=2, `write_data`=32'hdeadbeef. Register file r2 reads 32'hdeadbeef after that edge.
- IMM alone: r3, 16'hffff, IT_SIGNED → next cycle `write_immediate`=1, `write_immediate_type`=IT_SIGNED; r3 reads 32'hffffffff.
- LOAD (r1 ← 1), ALU (r4 ← 4) and IMM (r5, 16'h1234, IT_UNSIGNED) valid together → three consecutive writes in order r1, r4, r5. Expected `pending_mask` per cycle: 16'h0032, 16'h0032, 16'h0030, 16'h0020, then 0.
- With `REGFILE_ARB_STARVE_EN`, `STARVE_LIMIT`=4: LOAD valid every cycle, ALU valid from cycle 0 → ALU refused for 4 cycles, granted on the 5th; LOAD resumes after it.
- Without the macro, same stimulus over 20 cycles → `alu_ready` never asserts; 20 LOAD writes.
